// File: rtl/adc_spi_pkg.sv
// Shared constants, FSM state type and LFSR helper for the ADC SPI responder.
package adc_spi_pkg;

  localparam int ADC_BITS = 13;
  localparam int NUM_CH   = 4;
  localparam int CFG_BITS = 4;

  // Bit-counter terminal values for the request and data phases.
  localparam logic [3:0] CFG_LAST  = 4'(CFG_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(ADC_BITS - 1);

  // Dither LFSR: seed and Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CONFIG,
    NULL,
    DATA,
    DONE
  } adc_rsp_state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, followed by an
// edge-detect register producing single-cycle rise/fall strobes.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Pipeline: pin -> metastability stage -> synchronized -> previous sample.
  always_comb begin
    meta_d = pin;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-detect registers.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its source, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 13-bit, 4-channel sense ADC. The SPI pins are
// oversampled in the clk domain; a start bit plus {sgl, D2, D1, D0} selects a
// channel whose snapshot is shifted out MSB first after one null bit.
// Optional feature: define ADC_SPI_RESPONDER_DITHER_EN to XOR LFSR noise into
// the two LSBs of every snapshot.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ss_n,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic [ADC_BITS-1:0]    ch0_val,
  input  logic [ADC_BITS-1:0]    ch1_val,
  input  logic [ADC_BITS-1:0]    ch2_val,
  input  logic [ADC_BITS-1:0]    ch3_val,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CFG_BITS-1:0]    last_cfg,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // ---------------------------------------------------------------------------
  // Pin synchronization
  // ---------------------------------------------------------------------------
  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_pin_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .pin(ss_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin(mosi),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Abort is taken on the synchronized ss_n level (a rise implies it), and
  // mosi is only ever sampled on sclk rises, so these strobes are spare.
  logic unused_pin_strobes;
  assign unused_pin_strobes = ^{ss_rise, ss_fall, sclk_sync, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  adc_rsp_state_t         state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             cfg_q, cfg_d;
  logic [ADC_BITS-1:0]    shift_q, shift_d;
  logic                   miso_q, miso_d;
  logic                   frame_done_q, frame_done_d;
  logic [CFG_BITS-1:0]    last_cfg_q, last_cfg_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]             settle_q, settle_d;
  logic                   armed_q, armed_d;

  logic                   abort;
  logic [CFG_BITS-1:0]    req;
  logic [ADC_BITS-1:0]    snap;

  // Frame terminated by ss_n returning high anywhere outside IDLE.
  assign abort = ss_sync && (state_q != IDLE);

  // Full request as seen on the D0 rise: three earlier bits plus live mosi.
  assign req = {cfg_q, mosi_sync};

`ifdef ADC_SPI_RESPONDER_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // Snapshot word: channel mux, single-ended MSB clear, optional LSB dither.
  always_comb begin
    snap = '0;
    case (req[2:0])
      3'd0:    snap = ch0_val;
      3'd1:    snap = ch1_val;
      3'd2:    snap = ch2_val;
      3'd3:    snap = ch3_val;
      default: snap = '0;
    endcase
    if (req[3]) snap[ADC_BITS-1] = 1'b0;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
    snap[1:0] = snap[1:0] ^ lfsr_q[1:0];
`endif
  end

  // Reset-release qualifier: the ss_n synchronizer only reflects the real pin
  // after two clocks, and a frame already running at release must be skipped
  // until ss_n is genuinely observed high.
  always_comb begin
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & ss_sync);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (armed_q && !ss_sync)           state_d = WAIT_START;
      WAIT_START: if (sclk_rise && mosi_sync)        state_d = CONFIG;
      CONFIG:     if (sclk_rise && cnt_q == CFG_LAST) state_d = NULL;
      NULL:       if (sclk_fall)                     state_d = DATA;
      DATA:       if (sclk_fall && cnt_q == DATA_LAST) state_d = DONE;
      DONE:                                          state_d = DONE;
      default:                                       state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Datapath and output next-values driven by the current state.
  always_comb begin
    cnt_d        = cnt_q;
    cfg_d        = cfg_q;
    shift_d      = shift_q;
    miso_d       = miso_q;
    frame_done_d = 1'b0;
    last_cfg_d   = last_cfg_q;
    frame_cnt_d  = frame_cnt_q;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
    lfsr_d       = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
      end
      WAIT_START: begin
        if (sclk_rise && mosi_sync) cnt_d = '0;
      end
      CONFIG: begin
        if (sclk_rise) begin
          cfg_d = req[2:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CFG_LAST) begin
            shift_d    = snap;
            last_cfg_d = req;
            cnt_d      = '0;
          end
        end
      end
      NULL: begin
        if (sclk_fall) miso_d = 1'b0;
      end
      DATA: begin
        if (sclk_fall) begin
          miso_d  = shift_q[ADC_BITS-1];
          shift_d = {shift_q[ADC_BITS-2:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == DATA_LAST) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
            lfsr_d       = lfsr_next(lfsr_q);
`endif
          end
        end
      end
      DONE: begin
        if (sclk_fall) miso_d = 1'b0;
      end
      default: ;
    endcase
    if (abort) begin
      cnt_d        = '0;
      miso_d       = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
      lfsr_d       = lfsr_q;
`endif
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      cfg_q        <= '0;
      shift_q      <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
      last_cfg_q   <= '0;
      frame_cnt_q  <= '0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      shift_q      <= shift_d;
      miso_q       <= miso_d;
      frame_done_q <= frame_done_d;
      last_cfg_q   <= last_cfg_d;
      frame_cnt_q  <= frame_cnt_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
    end
  end

`ifdef ADC_SPI_RESPONDER_DITHER_EN
  // Dither LFSR, advanced once per completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`endif

  assign miso       = miso_q;
  assign miso_oe    = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign last_cfg   = last_cfg_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: a mode-0 SPI master driven at
// 1/16 of clk, compared against a channel-select/sign-clear reference model.
module tb_adc_spi_responder;

  localparam int HALF   = 8;   // clk cycles per sclk half period
  localparam int NUM_CH = 4;

  logic        clk;
  logic        rst_n;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [12:0] ch_val [NUM_CH];
  logic        busy;
  logic        frame_done;
  logic [3:0]  last_cfg;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int done_pulses = 0;
  logic b0_seen = 1'b0;
  int exp_frames = 0;

  adc_spi_responder #(.FRAME_CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (ss_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .ch0_val   (ch_val[0]),
    .ch1_val   (ch_val[1]),
    .ch2_val   (ch_val[2]),
    .ch3_val   (ch_val[3]),
    .busy      (busy),
    .frame_done(frame_done),
    .last_cfg  (last_cfg),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses and capture miso in the pulse cycle.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_pulses <= done_pulses + 1;
      b0_seen     <= miso;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: selected channel (or zero for 4-7), MSB cleared when single-ended.
  function automatic logic [12:0] model_word(input logic [3:0] cfg);
    int ch;
    logic [12:0] w;
    ch = int'(cfg[2:0]);
    w  = (ch < NUM_CH) ? ch_val[ch] : 13'h0000;
    if (cfg[3]) w = w & 13'h0FFF;
    return w;
  endfunction

  // Drops ss_n, sends lead zeros + start + cfg, then clocks n_rx more bits,
  // collecting miso on each of those rising edges (null bit first).
  task automatic spi_frame(input int lead, input logic [3:0] cfg, input int n_rx,
                           input logic chg3, output logic [13:0] rx);
    int   total;
    logic bitv;
    rx    = '0;
    total = lead + 5 + n_rx;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_3clk", busy, 1'b0);
    @(negedge clk);
    check("busy_at_3clk", busy, 1'b1);
    check("miso_oe_on", miso_oe, 1'b1);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      if (i < lead)           bitv = 1'b0;
      else if (i == lead)     bitv = 1'b1;
      else if (i < lead + 5)  bitv = cfg[lead + 4 - i];
      else                    bitv = 1'($urandom_range(0, 1));
      mosi = bitv;
      repeat (HALF) @(negedge clk);
      if (i >= lead + 5) rx = {rx[12:0], miso};
      sclk = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (chg3 && i == lead + 4 && k == 4) ch_val[3] = ch_val[3] ^ 13'h1FFF;
      end
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int lead, input logic [3:0] cfg,
                           input logic chg3);
    logic [12:0] exp_w;
    logic [13:0] rx;
    int          p0;
    exp_w = model_word(cfg);
    p0    = done_pulses;
    spi_frame(lead, cfg, 14, chg3, rx);
    exp_frames++;
    check({name, "_rx"}, 32'(rx), 32'({1'b0, exp_w}));
    check({name, "_done_pulses"}, 32'(done_pulses - p0), 32'd1);
    check({name, "_b0_at_done"}, 32'(b0_seen), 32'(exp_w[0]));
    spi_end();
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[15:0]));
    check({name, "_last_cfg"}, 32'(last_cfg), 32'(cfg));
  endtask

  task automatic randomize_channels();
    for (int c = 0; c < NUM_CH; c++) ch_val[c] = 13'($urandom);
  endtask

  initial begin
    logic [13:0] rx;
    logic [12:0] exp_w;
    logic [3:0]  cfg;
    int          p0;

    rst_n = 1'b0;
    ss_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    randomize_channels();
    repeat (4) @(negedge clk);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_last_cfg", last_cfg, 4'h0);
    check("rst_frame_cnt", frame_cnt, 16'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single-ended ch1: MSB forced low.
    ch_val[1] = 13'h0ABC;
    run_frame("sgl_ch1", 0, 4'b1001, 1'b0);

    // Differential ch2: MSB kept.
    ch_val[2] = 13'h1F00;
    run_frame("diff_ch2", 0, 4'b0010, 1'b0);

    // Leading zeros before the start bit.
    run_frame("lead0_ch1", 3, 4'b1001, 1'b0);

    // Out-of-range channel returns zeros.
    run_frame("ch5_zero", 0, 4'b1101, 1'b0);

    // Channel input changes after the snapshot.
    ch_val[3] = 13'h1234;
    run_frame("ch3_snapshot", 1, 4'b0011, 1'b1);
    check("ch3_changed", ch_val[3], 13'h1234 ^ 13'h1FFF);

    // Abort after null + 6 data bits.
    randomize_channels();
    cfg   = {1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3))};
    exp_w = model_word(cfg);
    p0    = done_pulses;
    spi_frame(0, cfg, 7, 1'b0, rx);
    check("abort_partial_rx", 32'(rx[6:0]), 32'({1'b0, exp_w[12:7]}));
    ss_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_oe_before_3clk", miso_oe, 1'b1);
    @(negedge clk);
    check("abort_miso_oe", miso_oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_pulses - p0), 32'd0);
    check("abort_frame_cnt", frame_cnt, 16'(exp_frames));
    run_frame("after_abort", 0, 4'($urandom), 1'b0);

    // Randomized frames over all request codes.
    for (int n = 0; n < 6; n++) begin
      randomize_channels();
      run_frame("rand", $urandom_range(0, 2), 4'($urandom), 1'b0);
    end

    // Reset pulsed mid-DATA: outputs return to reset values immediately.
    randomize_channels();
    spi_frame(0, 4'b0001, 5, 1'b0, rx);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", miso, 1'b0);
    check("midrst_miso_oe", miso_oe, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_last_cfg", last_cfg, 4'h0);
    check("midrst_frame_cnt", frame_cnt, 16'h0);
    exp_frames = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Frame still in progress after release must be ignored.
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    check("postrst_busy", busy, 1'b0);
    check("postrst_miso_oe", miso_oe, 1'b0);
    spi_end();
    run_frame("postrst", 0, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
